// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer for the 5-stage MIPS core: turns load-use hazards, taken branches
// resolved in MEM and data-memory wait states into PC / pipeline-register controls.
module pipeline_hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             M_PCSrc,
    input  logic             M_MemAccess,
    input  logic             M_MemReady,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             PipeHold,
    output logic             MEMWB_Bubble,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WAIT_W = $clog2(MAX_WAIT);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout_set;
    logic              flush_evt;
    logic              load_use;
    logic              rs_match;
    logic              rt_match;

    // $0 is hard-wired zero, so a load targeting it can never feed a stale value
    assign rs_match = (EX_Rt == ID_Rs);
    assign rt_match = ID_UsesRt && (EX_Rt == ID_Rt);
    assign load_use = EX_MemRead && (EX_Rt != 5'd0) && (rs_match || rt_match);

    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Flush  = 1'b0;
        PipeHold     = 1'b0;
        MEMWB_Bubble = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        flush_evt    = 1'b0;

        case (state)
            ST_RUN: begin
                if (M_PCSrc) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Flush  = 1'b1;
                    EXMEM_Flush = 1'b1;
                    flush_evt   = 1'b1;
                end else if (M_MemAccess && !M_MemReady) begin
                    PCWrite      = 1'b0;
                    IFID_Write   = 1'b0;
                    PipeHold     = 1'b1;
                    MEMWB_Bubble = 1'b1;
                    wait_cnt_nxt = WAIT_ONE;
                    state_nxt    = ST_WAIT;
                end else if (load_use) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_Flush = 1'b1;
                end
            end

            // the cycle the memory answers behaves as a normal RUN-idle cycle
            ST_WAIT: begin
                if (M_MemReady) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = ST_RUN;
                end else begin
                    PCWrite      = 1'b0;
                    IFID_Write   = 1'b0;
                    PipeHold     = 1'b1;
                    MEMWB_Bubble = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        timeout_set  = 1'b1;
                        wait_cnt_nxt = '0;
                        state_nxt    = ST_DRAIN;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WAIT_ONE;
                    end
                end
            end

            ST_DRAIN: begin
                IFID_Flush   = 1'b1;
                IDEX_Flush   = 1'b1;
                EXMEM_Flush  = 1'b1;
                MEMWB_Bubble = 1'b1;
                state_nxt    = ST_RUN;
            end

            default: begin
                wait_cnt_nxt = '0;
                state_nxt    = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // statistics saturate rather than wrap so a long run never reports a small count
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            MemTimeout <= 1'b0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (timeout_set) begin
                MemTimeout <= 1'b1;
            end
            if (!PCWrite && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + CNT_ONE;
            end
            if (flush_evt && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (default and small parameters)
// driven together and compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int A_MAX_WAIT = 16;
    localparam int A_CNT_MAX  = 65535;
    localparam int B_MAX_WAIT = 4;
    localparam int B_CNT_MAX  = 3;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRt;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        M_PCSrc;
    logic        M_MemAccess;
    logic        M_MemReady;

    logic        a_pcw, a_ifidw, a_ifidf, a_idexf, a_exmemf, a_hold, a_bub, a_tout;
    logic [15:0] a_stall, a_flush;
    logic        b_pcw, b_ifidw, b_ifidf, b_idexf, b_exmemf, b_hold, b_bub, b_tout;
    logic [1:0]  b_stall, b_flush;

    logic [6:0]  a_ctl;
    logic [6:0]  b_ctl;
    assign a_ctl = {a_pcw, a_ifidw, a_ifidf, a_idexf, a_exmemf, a_hold, a_bub};
    assign b_ctl = {b_pcw, b_ifidw, b_ifidf, b_idexf, b_exmemf, b_hold, b_bub};

    int total = 0;
    int bad   = 0;

    pipeline_hazard_controller dut_a (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .M_PCSrc(M_PCSrc),
        .M_MemAccess(M_MemAccess), .M_MemReady(M_MemReady),
        .PCWrite(a_pcw), .IFID_Write(a_ifidw), .IFID_Flush(a_ifidf), .IDEX_Flush(a_idexf),
        .EXMEM_Flush(a_exmemf), .PipeHold(a_hold), .MEMWB_Bubble(a_bub),
        .MemTimeout(a_tout), .StallCount(a_stall), .FlushCount(a_flush)
    );

    pipeline_hazard_controller #(.MAX_WAIT(B_MAX_WAIT), .CNT_W(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .M_PCSrc(M_PCSrc),
        .M_MemAccess(M_MemAccess), .M_MemReady(M_MemReady),
        .PCWrite(b_pcw), .IFID_Write(b_ifidw), .IFID_Flush(b_ifidf), .IDEX_Flush(b_idexf),
        .EXMEM_Flush(b_exmemf), .PipeHold(b_hold), .MEMWB_Bubble(b_bub),
        .MemTimeout(b_tout), .StallCount(b_stall), .FlushCount(b_flush)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // held = memory cycles already spent stalled on the current access (0 = not waiting)
    typedef struct packed {
        int held;
        bit drain;
        bit tout;
        int stall;
        int flush;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    // control vector order: PCWrite IFID_Write IFID_Flush IDEX_Flush EXMEM_Flush PipeHold MEMWB_Bubble
    localparam logic [6:0] C_IDLE   = 7'b1100000;
    localparam logic [6:0] C_BRANCH = 7'b1111100;
    localparam logic [6:0] C_MEMSTL = 7'b0000011;
    localparam logic [6:0] C_LDUSE  = 7'b0001000;
    localparam logic [6:0] C_DRAIN  = 7'b1111101;

    function automatic mdl_t model_reset();
        mdl_t m;
        m.held  = 0;
        m.drain = 1'b0;
        m.tout  = 1'b0;
        m.stall = 0;
        m.flush = 0;
        return m;
    endfunction

    function automatic void model_step(input mdl_t m, input int max_wait, input int cnt_max,
                                       output logic [6:0] ctl, output mdl_t n);
        bit lu;
        n   = m;
        ctl = C_IDLE;
        lu  = EX_MemRead && (EX_Rt != 0) &&
              ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
        if (m.drain) begin
            ctl     = C_DRAIN;
            n.drain = 1'b0;
        end else if (m.held > 0) begin
            if (M_MemReady) begin
                n.held = 0;
            end else begin
                ctl = C_MEMSTL;
                if (m.held + 1 == max_wait) begin
                    n.held  = 0;
                    n.drain = 1'b1;
                    n.tout  = 1'b1;
                end else begin
                    n.held = m.held + 1;
                end
            end
        end else if (M_PCSrc) begin
            ctl = C_BRANCH;
            if (m.flush < cnt_max) n.flush = m.flush + 1;
        end else if (M_MemAccess && !M_MemReady) begin
            ctl    = C_MEMSTL;
            n.held = 1;
        end else if (lu) begin
            ctl = C_LDUSE;
        end
        if (!ctl[6] && m.stall < cnt_max) n.stall = m.stall + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // compare both instances against the model; advance the model only out of reset
    task automatic evalAndCheck(input string tag);
        logic [6:0] ea;
        logic [6:0] eb;
        mdl_t na;
        mdl_t nb;
        model_step(ma, A_MAX_WAIT, A_CNT_MAX, ea, na);
        model_step(mb, B_MAX_WAIT, B_CNT_MAX, eb, nb);
        checkOutput({tag, ".a_ctl"},   32'(a_ctl),   32'(ea));
        checkOutput({tag, ".a_tout"},  32'(a_tout),  32'(ma.tout));
        checkOutput({tag, ".a_stall"}, 32'(a_stall), 32'(ma.stall));
        checkOutput({tag, ".a_flush"}, 32'(a_flush), 32'(ma.flush));
        checkOutput({tag, ".b_ctl"},   32'(b_ctl),   32'(eb));
        checkOutput({tag, ".b_tout"},  32'(b_tout),  32'(mb.tout));
        checkOutput({tag, ".b_stall"}, 32'(b_stall), 32'(mb.stall));
        checkOutput({tag, ".b_flush"}, 32'(b_flush), 32'(mb.flush));
        if (Reset) begin
            ma = na;
            mb = nb;
        end
    endtask

    // called at a falling edge: drive, settle, check, then run one rising edge
    task automatic applyStimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic memread, input logic [4:0] ex_rt,
                                 input logic pcsrc, input logic access, input logic ready);
        ID_Rs       = rs;
        ID_Rt       = rt;
        ID_UsesRt   = uses_rt;
        EX_MemRead  = memread;
        EX_Rt       = ex_rt;
        M_PCSrc     = pcsrc;
        M_MemAccess = access;
        M_MemReady  = ready;
        #1;
        evalAndCheck(tag);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetPulse(input string tag);
        Reset       = 1'b0;
        ID_Rs       = 5'd0;
        ID_Rt       = 5'd0;
        ID_UsesRt   = 1'b0;
        EX_MemRead  = 1'b0;
        EX_Rt       = 5'd0;
        M_PCSrc     = 1'b0;
        M_MemAccess = 1'b0;
        M_MemReady  = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        evalAndCheck({tag, ".async"});
        @(posedge Clk);
        @(negedge Clk);
        evalAndCheck({tag, ".held"});
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        ma = model_reset();
        mb = model_reset();
        @(negedge Clk);
        resetPulse("reset");
        idleStep("idle0");
        checkOutput("idle_stall_zero", 32'(a_stall), 32'd0);

        // single-cycle load-use stall on rs, then $0 and rt-source variants
        applyStimulus("lu_rs",     5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        idleStep("lu_rs_after");
        applyStimulus("lu_r0",     5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_rt",     5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_rt_nou", 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_noload", 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);

        // branch wins over a stalling memory access in the same cycle
        applyStimulus("br_mem",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        idleStep("br_mem_after");

        // three-cycle memory wait then completion
        for (int i = 0; i < 3; i++)
            applyStimulus("memwait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus("memdone",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idleStep("memdone_after");

        // memory never answers: both instances time out and drain
        for (int i = 0; i < 18; i++)
            applyStimulus("timeout", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus("release",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idleStep("post_timeout");
        checkOutput("a_tout_sticky", 32'(a_tout), 32'd1);
        checkOutput("b_tout_sticky", 32'(b_tout), 32'd1);

        // narrow counters saturate
        for (int i = 0; i < 5; i++)
            applyStimulus("branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        idleStep("branch_after");
        checkOutput("b_flush_sat", 32'(b_flush), 32'd3);

        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand",
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        // reset arriving while a memory wait is in progress
        applyStimulus("pre_rst_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus("pre_rst_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        resetPulse("rst_midwait");
        checkOutput("rst_a_stall_zero", 32'(a_stall), 32'd0);
        checkOutput("rst_a_tout_zero",  32'(a_tout),  32'd0);
        idleStep("after_rst");

        for (int i = 0; i < 200; i++) begin
            applyStimulus("rand2",
                          5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 2)), 1'($urandom_range(0, 6) == 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
